sdram_read_arbiter: RTL and testbench
=====================================

# sdram_read_arbiter

Parametrised N-client arbiter that shares one SDRAM burst-read master port among several cache read clients (instruction cache, data cache, prefetchers). Each client sees the same control/user handshake it would see on a dedicated read master: go/done/early_done plus streamed read data. The arbiter sits between the cache controllers and a single read master in the SDRAM system, and supports round-robin or fixed-priority arbitration. It handles zero-length requests locally.

## Interface
- N_CH, 2: number of read clients (≥2)
- ADDR_W, 26: byte address and length width
- DATA_W, 32: data word width
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins)

- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- c_go  in  N_CH  per-client request pulse
- c_fixed_location  in  N_CH  per-client fixed-address flag
- c_base  in  N_CH*ADDR_W  per-client start byte address, client i at [i*ADDR_W +: ADDR_W]
- c_length  in  N_CH*ADDR_W  per-client byte length
- c_done  out  N_CH  client idle (not pending, not owner)
- c_early_done  out  N_CH  all reads issued for this client
- c_read_buffer  in  N_CH  client pops one word
- c_data  out  DATA_W  read data, valid only for owner
- c_data_available  out  N_CH  word available to that client
- m_go, m_fixed_location  out  1  downstream request
- m_base, m_length  out  ADDR_W  downstream request
- m_done, m_early_done  in  1  downstream status
- m_read_buffer  out  1  downstream pop
- m_data  in  DATA_W  downstream data
- m_data_available  in  1  downstream FIFO non-empty

## Operation
- Per-client request latch: c_go[i] while c_done[i]=1 captures base/length/fixed into slot i and sets pending[i]. c_go while busy is ignored.
- Zero-length requests: a request with c_length=0 never sets pending. c_done stays 1 and nothing is forwarded.
- FSM states: IDLE, ISSUE, GUARD, STREAM.
  - IDLE: if any pending, arbiter picks owner, clears pending[owner], goes to ISSUE.
  - ISSUE: m_go=1 for exactly one cycle with the owner's slot values, then GUARD.
  - GUARD: one cycle. m_done is ignored because the downstream may still show done from its previous burst. Then STREAM.
  - STREAM: exit to IDLE when m_done=1 and m_data_available=0.
- Arbitration:
  - Round-robin: search starts at ptr. After a grant to k, ptr ← (k+1) mod N_CH. ptr resets to 0.
  - Fixed priority: lowest pending index wins.
- Data routing (combinational):
  - c_data = m_data.
  - c_data_available[i] = m_data_available & (owner==i) & state∈{GUARD,STREAM}.
  - m_read_buffer = c_read_buffer[owner] under the same qualification. Non-owner read_buffer is ignored.
- Status outputs:
  - c_done[i] = ~pending[i] & ~(owner==i & state≠IDLE).
  - c_early_done[i] = c_done[i] | (owner==i & state==STREAM & m_early_done).
- Simultaneous events: a c_go to the current owner on its completing cycle is ignored, since c_done is still 0. A new c_go from another client on a grant cycle is latched and competes next round.

## Timing
- Reset values:
  - state IDLE, pending 0, ptr 0.
  - m_go 0, m_base 0, m_length 0, m_fixed_location 0, m_read_buffer 0.
  - c_done all 1, c_early_done all 1, c_data_available 0.
- Latency: c_go at cycle T with arbiter idle → pending at T+1 → ISSUE at T+2 (m_go high T+2 only) → GUARD T+3 → STREAM T+4.
- Completion: if m_done=1 and m_data_available=0 at cycle E in STREAM, then IDLE and c_done[owner]=1 at E+1. The next grant's m_go can follow at E+2.
- Reset mid-operation: all pending requests and ownership are dropped. The downstream master is reset by the same reset. Clients must reissue.
- m_base/m_length/m_fixed_location are registered and held from ISSUE until the next ISSUE.

## Structure
- Package sdram_arb_pkg: FSM state enum, ARB_RR/ARB_FIXED constants, helper function for the slot index.
- Sub-module rr_arbiter: N_CH-bit request plus mode → one-hot grant and index. Holds the rotating pointer and advances it on a grant strobe.

## Test plan
- Single client: ch0 go base 0x100 len 16 → m_go at T+2 with base 0x100, len 16. Four words pass to ch0 in order. c_done[0] rises the cycle after m_done=1 and data drained.
- Contention, ARB_MODE=0: ch0 and ch1 go together, three times in a row → grant order 0, 1, 0, 1, 0, 1. With ARB_MODE=1 → grant order 0, 1 each round.
- Zero length: ch1 go with length 0 → c_done[1] stays 1, m_go never asserted.
- Busy ignore: ch0 go base 0x200 while ch0 is streaming base 0x100 → no second m_go. Only the 0x100 data is delivered.
- Isolation: ch1 pulses read_buffer while ch0 owns the port → m_read_buffer follows only ch0, c_data_available[1]=0 throughout.
- Reset mid-STREAM: reset asserted with ch1 pending → next cycle IDLE, all c_done=1, no m_go follows.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared state type, arbitration modes and slot helper for the SDRAM read arbiter
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_GUARD  = 2'd2,
    ST_STREAM = 2'd3
  } arb_state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Lowest bit of client idx's field inside a packed per-client bus
  function automatic int slot_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin / fixed-priority grant selection with rotating pointer
module rr_arbiter #(
  parameter int N_CH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          req_i,
  input  logic                     fixed_i,
  input  logic                     grant_en_i,
  output logic [N_CH-1:0]          grant_o,
  output logic [$clog2(N_CH)-1:0]  grant_idx_o
);

  localparam int IDX_W = $clog2(N_CH);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  // First requester found searching upward from ptr_q (round-robin) or from index 0 (fixed)
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int off = 0; off < N_CH; off++) begin
      cand = fixed_i ? IDX_W'(off) : IDX_W'((int'(ptr_q) + off) % N_CH);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

  // Pointer moves just past the granted client so it becomes lowest priority next round
  always_comb begin
    ptr_d = ptr_q;
    if (grant_en_i && found) begin
      ptr_d = (grant_idx_o == IDX_W'(N_CH - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sdram_read_arbiter.sv
// rtl/sdram_read_arbiter.sv - shares one SDRAM burst-read master among N cache read clients
module sdram_read_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int ADDR_W   = 26,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH-1:0]        c_go,
  input  logic [N_CH-1:0]        c_fixed_location,
  input  logic [N_CH*ADDR_W-1:0] c_base,
  input  logic [N_CH*ADDR_W-1:0] c_length,
  output logic [N_CH-1:0]        c_done,
  output logic [N_CH-1:0]        c_early_done,
  input  logic [N_CH-1:0]        c_read_buffer,
  output logic [DATA_W-1:0]      c_data,
  output logic [N_CH-1:0]        c_data_available,
  output logic                   m_go,
  output logic                   m_fixed_location,
  output logic [ADDR_W-1:0]      m_base,
  output logic [ADDR_W-1:0]      m_length,
  input  logic                   m_done,
  input  logic                   m_early_done,
  output logic                   m_read_buffer,
  input  logic [DATA_W-1:0]      m_data,
  input  logic                   m_data_available
);

  localparam int IDX_W = $clog2(N_CH);

  arb_state_e        state_q;
  logic [IDX_W-1:0]  owner_q;
  logic [N_CH-1:0]   pending_q;
  logic [N_CH-1:0]   pending_d;
  logic [N_CH-1:0]   accept;
  logic [ADDR_W-1:0] slot_base_q [N_CH];
  logic [ADDR_W-1:0] slot_len_q  [N_CH];
  logic [N_CH-1:0]   slot_fixed_q;
  logic              m_go_q;
  logic              m_fixed_q;
  logic [ADDR_W-1:0] m_base_q;
  logic [ADDR_W-1:0] m_len_q;
  logic [N_CH-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_en;
  logic              owner_live;

  assign grant_en   = (state_q == ST_IDLE) && (|pending_q);
  assign owner_live = (state_q == ST_GUARD) || (state_q == ST_STREAM);

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_i       (pending_q),
    .fixed_i     (ARB_MODE == ARB_FIXED),
    .grant_en_i  (grant_en),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // Per-client status, data-valid routing and request acceptance (zero-length never accepted)
  always_comb begin
    c_done           = '0;
    c_early_done     = '0;
    c_data_available = '0;
    accept           = '0;
    for (int i = 0; i < N_CH; i++) begin
      c_done[i]           = ~pending_q[i] & ~((owner_q == IDX_W'(i)) && (state_q != ST_IDLE));
      c_early_done[i]     = c_done[i] |
                            ((owner_q == IDX_W'(i)) && (state_q == ST_STREAM) && m_early_done);
      c_data_available[i] = m_data_available && (owner_q == IDX_W'(i)) && owner_live;
      accept[i]           = c_go[i] && c_done[i] &&
                            (c_length[slot_lo(i, ADDR_W) +: ADDR_W] != '0);
    end
  end

  // New requests set pending; the granted slot is cleared as it moves into the master
  always_comb begin
    pending_d = pending_q | accept;
    if (grant_en) pending_d = pending_d & ~grant;
  end

  // Request slots capture the client's parameters when a request is accepted
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (accept[i]) begin
        slot_base_q[i]  <= c_base[slot_lo(i, ADDR_W) +: ADDR_W];
        slot_len_q[i]   <= c_length[slot_lo(i, ADDR_W) +: ADDR_W];
        slot_fixed_q[i] <= c_fixed_location[i];
      end
    end
  end

  // Ownership FSM; downstream request fields are registered at grant and held until the next grant
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      pending_q <= '0;
      m_go_q    <= 1'b0;
      m_fixed_q <= 1'b0;
      m_base_q  <= '0;
      m_len_q   <= '0;
    end else begin
      pending_q <= pending_d;
      m_go_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_en) begin
            owner_q   <= grant_idx;
            m_go_q    <= 1'b1;
            m_base_q  <= slot_base_q[grant_idx];
            m_len_q   <= slot_len_q[grant_idx];
            m_fixed_q <= slot_fixed_q[grant_idx];
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE:  state_q <= ST_GUARD;
        // Downstream done may still reflect its previous burst here, so it is not looked at
        ST_GUARD:  state_q <= ST_STREAM;
        ST_STREAM: begin
          if (m_done && !m_data_available) state_q <= ST_IDLE;
        end
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_go             = m_go_q;
  assign m_base           = m_base_q;
  assign m_length         = m_len_q;
  assign m_fixed_location = m_fixed_q;
  assign m_read_buffer    = c_read_buffer[owner_q] && owner_live;
  assign c_data           = m_data;

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// tb/tb_sdram_read_arbiter.sv - scoreboard bench for round-robin and fixed-priority arbiter instances
module tb_sdram_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  c_go;
  logic [1:0]  c_fix;
  logic [1:0]  c_rb;
  logic [51:0] c_base;
  logic [51:0] c_len;

  logic [1:0]  c_done_w  [2];
  logic [1:0]  c_early_w [2];
  logic [1:0]  c_av_w    [2];
  logic [31:0] c_data_w  [2];
  logic        m_go_w    [2];
  logic        m_fix_w   [2];
  logic        m_rb_w    [2];
  logic [25:0] m_base_w  [2];
  logic [25:0] m_len_w   [2];
  logic        m_done_w  [2];
  logic        m_early_w [2];
  logic        m_av_w    [2];
  logic [31:0] m_data_w  [2];

  int checks   = 0;
  int failures = 0;
  int rr_ptr   = 0;

  logic [52:0] exp_go0 [$];
  logic [52:0] exp_go1 [$];
  logic [32:0] exp_d0  [$];
  logic [32:0] exp_d1  [$];

  always #5 clk = ~clk;

  // Instance 0 is round-robin, instance 1 fixed priority; each has its own downstream master model
  for (genvar g = 0; g < 2; g++) begin : g_dut
    int          pushed;
    int          popped;
    int          total;
    logic [25:0] mbase;

    sdram_read_arbiter #(
      .N_CH     (2),
      .ADDR_W   (26),
      .DATA_W   (32),
      .ARB_MODE (g)
    ) u_dut (
      .clk              (clk),
      .reset            (reset),
      .c_go             (c_go),
      .c_fixed_location (c_fix),
      .c_base           (c_base),
      .c_length         (c_len),
      .c_done           (c_done_w[g]),
      .c_early_done     (c_early_w[g]),
      .c_read_buffer    (c_rb),
      .c_data           (c_data_w[g]),
      .c_data_available (c_av_w[g]),
      .m_go             (m_go_w[g]),
      .m_fixed_location (m_fix_w[g]),
      .m_base           (m_base_w[g]),
      .m_length         (m_len_w[g]),
      .m_done           (m_done_w[g]),
      .m_early_done     (m_early_w[g]),
      .m_read_buffer    (m_rb_w[g]),
      .m_data           (m_data_w[g]),
      .m_data_available (m_av_w[g])
    );

    // Master model: one word fetched per cycle after go, data word k = base + 4k
    always @(posedge clk) begin
      if (reset) begin
        pushed <= 0;
        popped <= 0;
        total  <= 0;
        mbase  <= '0;
      end else if (m_go_w[g]) begin
        pushed <= 0;
        popped <= 0;
        total  <= int'(m_len_w[g]) / 4;
        mbase  <= m_base_w[g];
      end else begin
        if (pushed < total) pushed <= pushed + 1;
        if (m_rb_w[g] && (popped < pushed)) popped <= popped + 1;
      end
    end

    assign m_done_w[g]  = (pushed == total);
    assign m_early_w[g] = (pushed == total);
    assign m_av_w[g]    = (popped < pushed);
    assign m_data_w[g]  = 32'(mbase) + 32'(popped * 4);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] cl_base(input int cl);
    return (cl == 0) ? 26'h100 : 26'h300;
  endfunction

  function automatic logic [25:0] cl_len(input int cl);
    return (cl == 0) ? 26'd16 : 26'd8;
  endfunction

  task automatic push_exp(input int g, input int cl, input logic fx);
    logic [25:0] b;
    logic [25:0] l;
    logic [32:0] d;
    b = cl_base(cl);
    l = cl_len(cl);
    if (g == 0) exp_go0.push_back({fx, b, l});
    else        exp_go1.push_back({fx, b, l});
    for (int k = 0; k < int'(l) / 4; k++) begin
      d = {cl[0], 32'(b) + 32'(4 * k)};
      if (g == 0) exp_d0.push_back(d);
      else        exp_d1.push_back(d);
    end
  endtask

  task automatic push_single(input int cl, input logic fx);
    push_exp(0, cl, fx);
    push_exp(1, cl, fx);
    rr_ptr = (cl + 1) % 2;
  endtask

  // Both clients together: RR serves from rr_ptr, fixed always serves 0 first; ch1 uses fixed location
  task automatic push_pair();
    int first;
    first = rr_ptr;
    push_exp(0, first, first == 1);
    push_exp(0, 1 - first, first == 0);
    push_exp(1, 0, 1'b0);
    push_exp(1, 1, 1'b1);
  endtask

  task automatic drive_go(input logic [1:0] mask, input logic [1:0] fx,
                          input logic [25:0] b0, input logic [25:0] l0,
                          input logic [25:0] b1, input logic [25:0] l1);
    @(negedge clk);
    c_base = {b1, b0};
    c_len  = {l1, l0};
    c_fix  = fx;
    c_go   = mask;
    @(negedge clk);
    c_go   = 2'b00;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(c_done_w[0] == 2'b11 && c_done_w[1] == 2'b11) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 300), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_go0.delete();
    exp_go1.delete();
    exp_d0.delete();
    exp_d1.delete();
    rr_ptr = 0;
  endtask

  task automatic mon(input int g);
    logic [52:0] e;
    logic [32:0] d;
    int          sz;
    if (m_go_w[g]) begin
      sz = (g == 0) ? exp_go0.size() : exp_go1.size();
      if (sz == 0) begin
        chk("m_go_unexpected", 32'(m_go_w[g]), 32'd0);
      end else begin
        if (g == 0) e = exp_go0.pop_front();
        else        e = exp_go1.pop_front();
        chk("m_base", 32'(m_base_w[g]), 32'(e[51:26]));
        chk("m_length", 32'(m_len_w[g]), 32'(e[25:0]));
        chk("m_fixed", 32'(m_fix_w[g]), 32'(e[52]));
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (c_av_w[g][i] && c_rb[i]) begin
        sz = (g == 0) ? exp_d0.size() : exp_d1.size();
        if (sz == 0) begin
          chk("data_unexpected", 32'(c_av_w[g][i]), 32'd0);
        end else begin
          if (g == 0) d = exp_d0.pop_front();
          else        d = exp_d1.pop_front();
          chk("data_client", 32'(i), 32'(d[32]));
          chk("data_word", c_data_w[g], d[31:0]);
        end
      end
    end
  endtask

  // Scoreboard side: every grant and every delivered word is matched against the expected queues
  always @(negedge clk) begin
    if (!reset) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    int n;
    reset  = 1'b1;
    c_go   = 2'b00;
    c_fix  = 2'b00;
    c_rb   = 2'b11;
    c_base = '0;
    c_len  = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_c_done", 32'(c_done_w[g]), 32'd3);
      chk("rst_c_early_done", 32'(c_early_w[g]), 32'd3);
      chk("rst_c_data_available", 32'(c_av_w[g]), 32'd0);
      chk("rst_m_go", 32'(m_go_w[g]), 32'd0);
      chk("rst_m_base", 32'(m_base_w[g]), 32'd0);
      chk("rst_m_length", 32'(m_len_w[g]), 32'd0);
      chk("rst_m_fixed", 32'(m_fix_w[g]), 32'd0);
      chk("rst_m_read_buffer", 32'(m_rb_w[g]), 32'd0);
    end
    reset = 1'b0;

    // Single client: latency, data order, completion timing
    push_single(0, 1'b0);
    drive_go(2'b01, 2'b00, 26'h100, 26'd16, 26'h300, 26'd8);
    chk("lat_pending_c_done", 32'(c_done_w[0][0]), 32'd0);
    chk("lat_t1_m_go", 32'(m_go_w[0]), 32'd0);
    @(negedge clk);
    chk("lat_t2_m_go_rr", 32'(m_go_w[0]), 32'd1);
    chk("lat_t2_m_go_fixed", 32'(m_go_w[1]), 32'd1);
    @(negedge clk);
    chk("lat_t3_m_go", 32'(m_go_w[0]), 32'd0);
    n = 0;
    while (!(m_done_w[0] && !m_av_w[0]) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("complete_timeout", 32'(n < 60), 32'd1);
    chk("complete_c_done_before", 32'(c_done_w[0][0]), 32'd0);
    @(negedge clk);
    chk("complete_c_done_after", 32'(c_done_w[0][0]), 32'd1);
    wait_idle();

    // Contention from a fresh pointer: three simultaneous rounds
    do_reset();
    for (int r = 0; r < 3; r++) begin
      push_pair();
      drive_go(2'b11, 2'b10, 26'h100, 26'd16, 26'h300, 26'd8);
      wait_idle();
    end
    chk("contention_go_drained_rr", 32'(exp_go0.size()), 32'd0);
    chk("contention_go_drained_fixed", 32'(exp_go1.size()), 32'd0);

    // After a lone ch0 grant the round-robin pointer favours ch1; fixed priority still picks ch0
    push_single(0, 1'b0);
    drive_go(2'b01, 2'b00, 26'h100, 26'd16, 26'h300, 26'd8);
    wait_idle();
    push_pair();
    drive_go(2'b11, 2'b10, 26'h100, 26'd16, 26'h300, 26'd8);
    wait_idle();
    chk("rotate_go_drained_rr", 32'(exp_go0.size()), 32'd0);
    chk("rotate_go_drained_fixed", 32'(exp_go1.size()), 32'd0);

    // Zero length request is absorbed locally
    drive_go(2'b10, 2'b00, 26'h100, 26'd16, 26'h300, 26'd0);
    chk("zero_len_c_done_rr", 32'(c_done_w[0][1]), 32'd1);
    chk("zero_len_c_done_fixed", 32'(c_done_w[1][1]), 32'd1);
    repeat (8) @(negedge clk);

    // Busy ignore and read_buffer isolation while ch0 owns the port
    c_rb = 2'b00;
    push_single(0, 1'b0);
    drive_go(2'b01, 2'b00, 26'h100, 26'd16, 26'h300, 26'd8);
    repeat (3) @(negedge clk);
    drive_go(2'b01, 2'b00, 26'h200, 26'd16, 26'h300, 26'd8);
    c_rb = 2'b10;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("iso_m_read_buffer", 32'(m_rb_w[0]), 32'd0);
      chk("iso_c_data_available1", 32'(c_av_w[0][1]), 32'd0);
    end
    c_rb = 2'b01;
    wait_idle();
    c_rb = 2'b11;
    repeat (5) @(negedge clk);
    chk("busy_go_drained", 32'(exp_go0.size()), 32'd0);
    chk("busy_data_drained", 32'(exp_d0.size()), 32'd0);

    // Reset while ch0 streams and ch1 is pending
    c_rb = 2'b00;
    push_single(0, 1'b0);
    drive_go(2'b01, 2'b00, 26'h100, 26'd16, 26'h300, 26'd8);
    repeat (3) @(negedge clk);
    drive_go(2'b10, 2'b10, 26'h100, 26'd16, 26'h300, 26'd8);
    chk("mid_ch1_pending", 32'(c_done_w[0][1]), 32'd0);
    do_reset();
    chk("post_rst_c_done_rr", 32'(c_done_w[0]), 32'd3);
    chk("post_rst_c_done_fixed", 32'(c_done_w[1]), 32'd3);
    chk("post_rst_c_data_available", 32'(c_av_w[0]), 32'd0);
    c_rb = 2'b11;
    repeat (12) @(negedge clk);
    chk("post_rst_go_empty", 32'(exp_go0.size()), 32'd0);
    chk("final_data_drained_rr", 32'(exp_d0.size()), 32'd0);
    chk("final_data_drained_fixed", 32'(exp_d1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
